// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_pkg
// Purpose  : State encoding and line levels shared by the serial TX scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick; search begins at i_pointer and wraps.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_pointer,
  input  logic                       i_enable,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_win_id,
  output logic                       o_any
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW:0] w_sum;

  always_comb begin
    o_grant  = '0;
    o_win_id = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit keeps pointer+offset from overflowing before the wrap.
      w_sum = {1'b0, i_pointer} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PW+1)'(NUM_REQ);
      end
      if (i_enable && !o_any && i_req_valid[w_sum[PW-1:0]]) begin
        o_any                     = 1'b1;
        o_grant[w_sum[PW-1:0]]    = 1'b1;
        o_win_id                  = w_sum[PW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_scheduler
// Purpose  : Round-robin shares one LSB-first framed serial line between
//            NUM_REQ producers. Define SERIAL_TX_PARITY_EN for an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          REQ_VALID,
  input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]          REQ_READY,
  output logic                        SER_OUT,
  output logic                        SER_EN,
  output logic [$clog2(NUM_REQ)-1:0]  GRANT_ID,
  output logic                        BUSY,
  output logic                        DONE
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_bit_idx;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_grant_id;
  logic [PW-1:0]       w_win;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_any;
  logic                w_arb_en;
  logic                w_tick_last;
  logic                w_ser_next;
  logic                w_en_next;
  logic                r_ser_out;
  logic                r_ser_en;
  logic                r_done;
  logic [DATA_W-1:0]   w_words [NUM_REQ];
  logic [DATA_W-1:0]   w_word;
`ifdef SERIAL_TX_PARITY_EN
  logic                r_parity;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_words[gi] = REQ_DATA[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Reset gates arbitration so no accept strobe is seen while RST is held.
  assign w_arb_en    = (r_state == IDLE) && !RST;
  assign w_word      = w_words[w_win];
  assign w_tick_last = (r_cnt == CNT_LAST);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req_valid (REQ_VALID),
    .i_pointer   (r_ptr),
    .i_enable    (w_arb_en),
    .o_grant     (w_grant),
    .o_win_id    (w_win),
    .o_any       (w_any)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (w_any) w_state_next = START;
      START:  if (w_tick_last) w_state_next = DATA;
      DATA: begin
        if (w_tick_last && (r_bit_idx == IDX_LAST)) begin
`ifdef SERIAL_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (w_tick_last) w_state_next = STOP;
`endif
      STOP:   if (w_tick_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_shift_next = r_shift;
    if (w_any) begin
      w_shift_next = w_word;
    end else if ((r_state == DATA) && w_tick_last) begin
      w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
    end
  end

  // Line level is computed from next state so the registered pin lines up with it.
  always_comb begin
    w_ser_next = LINE_IDLE;
    w_en_next  = (w_state_next != IDLE);
    case (w_state_next)
      START:  w_ser_next = START_LEVEL;
      DATA:   w_ser_next = w_shift_next[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: w_ser_next = r_parity;
`endif
      STOP:   w_ser_next = STOP_LEVEL;
      default: w_ser_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_ser_out  <= LINE_IDLE;
      r_ser_en   <= 1'b0;
      r_done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_cnt     <= ((r_state == IDLE) || w_tick_last) ? '0 : r_cnt + CW'(1);
      r_shift   <= w_shift_next;
      r_ser_out <= w_ser_next;
      r_ser_en  <= w_en_next;
      r_done    <= (r_state == STOP) && w_tick_last;
      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_tick_last) begin
        r_bit_idx <= (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + IW'(1);
      end
      if (w_any) begin
        r_grant_id <= w_win;
        r_ptr      <= (w_win == PTR_LAST) ? '0 : w_win + PW'(1);
`ifdef SERIAL_TX_PARITY_EN
        r_parity   <= ^w_word;
`endif
      end
    end
  end

  assign REQ_READY = w_grant;
  assign SER_OUT   = r_ser_out;
  assign SER_EN    = r_ser_en;
  assign GRANT_ID  = r_grant_id;
  assign BUSY      = (r_state != IDLE);
  assign DONE      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_scheduler
// Purpose  : Directed self-checking bench for serial_tx_scheduler (2 req, 8 bit, 4 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_scheduler;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  REQ_VALID;
  logic [15:0] REQ_DATA;
  logic [1:0]  REQ_READY;
  logic        SER_OUT;
  logic        SER_EN;
  logic [0:0]  GRANT_ID;
  logic        BUSY;
  logic        DONE;

  int n_cmp = 0;
  int n_bad = 0;

  logic       cap_ser   [0:63];
  logic       cap_en    [0:63];
  logic       cap_busy  [0:63];
  logic       cap_done  [0:63];
  logic       cap_gid   [0:63];
  logic [1:0] cap_ready [0:63];

  serial_tx_scheduler #(
    .NUM_REQ      (2),
    .DATA_W       (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .SER_OUT   (SER_OUT),
    .SER_EN    (SER_EN),
    .GRANT_ID  (GRANT_ID),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected line level in frame cycle k (1-based).
  function automatic logic exp_bit(input logic [7:0] w, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  // Records outputs on negedges 1..ncyc after the current point; inputs change at cycle 1.
  task automatic capture(input int ncyc, input logic [1:0] v_after, input logic [15:0] d_after);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge CLK);
      cap_ser[k]   = SER_OUT;
      cap_en[k]    = SER_EN;
      cap_busy[k]  = BUSY;
      cap_done[k]  = DONE;
      cap_gid[k]   = GRANT_ID[0];
      cap_ready[k] = REQ_READY;
      if (k == 1) begin
        REQ_VALID = v_after;
        REQ_DATA  = d_after;
      end
    end
  endtask

  task automatic do_reset();
    REQ_VALID = 2'b00;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    REQ_VALID = 2'b11;
    REQ_DATA  = 16'h2211;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_cmp++;
      if ({SER_OUT, SER_EN, BUSY, DONE, REQ_READY, GRANT_ID} !== 7'b1000000) begin
        n_bad++;
        $display("FAIL reset_c%0d: got ser/en/busy/done/ready/gid=%b required 1000000", c,
                 {SER_OUT, SER_EN, BUSY, DONE, REQ_READY, GRANT_ID});
      end
    end
    REQ_VALID = 2'b00;
    RST       = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    logic [NBITS-1:0] seq;
`ifdef SERIAL_TX_PARITY_EN
    seq = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    seq = {1'b1, 8'hA5, 1'b0};
`endif
    do_reset();
    REQ_DATA  = 16'h00A5;
    REQ_VALID = 2'b01;
    #1;
    n_cmp++;
    if (REQ_READY !== 2'b01) begin
      n_bad++; $display("FAIL single_ready: got %b required 01", REQ_READY);
    end
    capture(FRAME + 2, 2'b00, 16'hFF5A);
    n_cmp++;
    if (cap_gid[1] !== 1'b0) begin
      n_bad++; $display("FAIL single_gid: got %b required 0", cap_gid[1]);
    end
    for (int k = 1; k <= FRAME; k++) begin
      n_cmp++;
      if ({cap_ser[k], cap_en[k], cap_busy[k], cap_done[k]} !== {seq[(k-1)/CPB], 3'b110}) begin
        n_bad++;
        $display("FAIL single_cyc%0d: got ser/en/busy/done=%b required %b", k,
                 {cap_ser[k], cap_en[k], cap_busy[k], cap_done[k]}, {seq[(k-1)/CPB], 3'b110});
      end
    end
    n_cmp++;
    if ({cap_ser[FRAME+1], cap_en[FRAME+1], cap_busy[FRAME+1], cap_done[FRAME+1]} !== 4'b1001) begin
      n_bad++; $display("FAIL single_done: got %b required 1001",
                        {cap_ser[FRAME+1], cap_en[FRAME+1], cap_busy[FRAME+1], cap_done[FRAME+1]});
    end
    n_cmp++;
    if ({cap_ser[FRAME+2], cap_en[FRAME+2], cap_busy[FRAME+2], cap_done[FRAME+2]} !== 4'b1000) begin
      n_bad++; $display("FAIL single_after: got %b required 1000",
                        {cap_ser[FRAME+2], cap_en[FRAME+2], cap_busy[FRAME+2], cap_done[FRAME+2]});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    REQ_DATA  = 16'h2211;
    REQ_VALID = 2'b11;
    #1;
    n_cmp++;
    if (REQ_READY !== 2'b01) begin
      n_bad++; $display("FAIL b2b_ready0: got %b required 01", REQ_READY);
    end
    // Requester 0's word changes mid-frame; the captured 8'h11 must still go out.
    capture(FRAME + 1, 2'b11, 16'h2277);
    n_cmp++;
    if (cap_gid[1] !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gid0: got %b required 0", cap_gid[1]);
    end
    for (int k = 1; k <= FRAME; k++) begin
      n_cmp++;
      if (cap_ser[k] !== exp_bit(8'h11, k)) begin
        n_bad++; $display("FAIL b2b_f0_cyc%0d: got %b required %b", k, cap_ser[k], exp_bit(8'h11, k));
      end
    end
    n_cmp++;
    if ({cap_done[FRAME+1], cap_en[FRAME+1], cap_ready[FRAME+1]} !== 4'b1010) begin
      n_bad++; $display("FAIL b2b_gap: got done/en/ready=%b required 1010",
                        {cap_done[FRAME+1], cap_en[FRAME+1], cap_ready[FRAME+1]});
    end
    capture(FRAME + 1, 2'b00, 16'h0000);
    n_cmp++;
    if (cap_gid[1] !== 1'b1) begin
      n_bad++; $display("FAIL b2b_gid1: got %b required 1", cap_gid[1]);
    end
    for (int k = 1; k <= FRAME; k++) begin
      n_cmp++;
      if (cap_ser[k] !== exp_bit(8'h22, k)) begin
        n_bad++; $display("FAIL b2b_f1_cyc%0d: got %b required %b", k, cap_ser[k], exp_bit(8'h22, k));
      end
    end
    n_cmp++;
    if (cap_done[FRAME+1] !== 1'b1) begin
      n_bad++; $display("FAIL b2b_done1: got %b required 1", cap_done[FRAME+1]);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_rdy;
    do_reset();
    REQ_DATA  = 16'h4433;
    REQ_VALID = 2'b11;
    #1;
    for (int f = 0; f < 4; f++) begin
      exp_rdy = (f % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (REQ_READY !== exp_rdy) begin
        n_bad++; $display("FAIL fair_ready%0d: got %b required %b", f, REQ_READY, exp_rdy);
      end
      capture(FRAME + 1, 2'b11, 16'h4433);
      n_cmp++;
      if (cap_gid[1] !== logic'(f % 2)) begin
        n_bad++; $display("FAIL fair_gid%0d: got %b required %0d", f, cap_gid[1], f % 2);
      end
    end
    REQ_VALID = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_abort();
    logic seen_done;
    do_reset();
    REQ_DATA  = 16'h00FF;
    REQ_VALID = 2'b01;
    #1;
    n_cmp++;
    if (REQ_READY !== 2'b01) begin
      n_bad++; $display("FAIL abort_ready: got %b required 01", REQ_READY);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      if (k == 1) REQ_VALID = 2'b00;
    end
    n_cmp++;
    if ({SER_OUT, BUSY} !== 2'b11) begin
      n_bad++; $display("FAIL abort_cyc15: got ser/busy=%b required 11", {SER_OUT, BUSY});
    end
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({SER_OUT, SER_EN, BUSY, DONE, GRANT_ID} !== 5'b10000) begin
      n_bad++; $display("FAIL abort_cyc16: got ser/en/busy/done/gid=%b required 10000",
                        {SER_OUT, SER_EN, BUSY, DONE, GRANT_ID});
    end
    RST = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < FRAME + 5; k++) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_bad++; $display("FAIL abort_nodone: got activity=%b required 0", seen_done);
    end
    // Requester 0 dropped VALID: requester 1 must win even though the pointer is 0.
    REQ_DATA  = 16'h3C00;
    REQ_VALID = 2'b10;
    #1;
    n_cmp++;
    if (REQ_READY !== 2'b10) begin
      n_bad++; $display("FAIL abort_fresh_ready: got %b required 10", REQ_READY);
    end
    capture(FRAME + 1, 2'b00, 16'h0000);
    n_cmp++;
    if (cap_gid[1] !== 1'b1) begin
      n_bad++; $display("FAIL abort_fresh_gid: got %b required 1", cap_gid[1]);
    end
    for (int k = 1; k <= FRAME; k++) begin
      n_cmp++;
      if (cap_ser[k] !== exp_bit(8'h3C, k)) begin
        n_bad++; $display("FAIL abort_fresh_cyc%0d: got %b required %b", k, cap_ser[k], exp_bit(8'h3C, k));
      end
    end
    n_cmp++;
    if (cap_done[FRAME+1] !== 1'b1) begin
      n_bad++; $display("FAIL abort_fresh_done: got %b required 1", cap_done[FRAME+1]);
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    REQ_DATA  = 16'h0007;
    REQ_VALID = 2'b01;
    #1;
    capture(45, 2'b00, 16'h0000);
    for (int k = 33; k <= 36; k++) begin
      n_cmp++;
      if (cap_ser[k] !== 1'b0) begin
        n_bad++; $display("FAIL par_bit7_cyc%0d: got %b required 0", k, cap_ser[k]);
      end
    end
    for (int k = 37; k <= 44; k++) begin
      n_cmp++;
      if ({cap_ser[k], cap_en[k], cap_done[k]} !== 3'b110) begin
        n_bad++; $display("FAIL par_tail_cyc%0d: got ser/en/done=%b required 110", k,
                          {cap_ser[k], cap_en[k], cap_done[k]});
      end
    end
    n_cmp++;
    if ({cap_en[45], cap_done[45]} !== 2'b01) begin
      n_bad++; $display("FAIL par_done: got en/done=%b required 01", {cap_en[45], cap_done[45]});
    end
  endtask
`endif

  initial begin
    RST       = 1'b1;
    REQ_VALID = 2'b00;
    REQ_DATA  = 16'h0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_abort();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
